// File: rtl/branch_compare_pipe.sv
// Two-stage pipelined branch comparator: chunked signed/unsigned compare plus RV32I funct3 resolution.
// Optional macro BRANCH_COMPARE_FLUSH_EN adds flush_i, which drops every in-flight request.
module branch_compare_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef BRANCH_COMPARE_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       br_op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             equal_o,
  output logic             alarger_o,
  output logic             blarger_o,
  output logic             taken_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int NCHUNK = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("branch_compare_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic              flush_s;
  logic              signed_s;
  logic [WIDTH-1:0]  a_m_s;
  logic [WIDTH-1:0]  b_m_s;
  logic [NCHUNK-1:0] eq_s;
  logic [NCHUNK-1:0] gt_s;
  logic              accept_s;
  logic              s2_free_s;
  logic              s1_adv_s;

  logic              s1_valid_r;
  logic [NCHUNK-1:0] s1_eq_r;
  logic [NCHUNK-1:0] s1_gt_r;
  logic [2:0]        s1_op_r;
  logic [TAG_W-1:0]  s1_tag_r;

  logic              equal_s;
  logic              alarger_s;
  logic              blarger_s;
  logic              taken_s;
  logic              illegal_s;

`ifdef BRANCH_COMPARE_FLUSH_EN
  assign flush_s = flush_i;
`else
  assign flush_s = 1'b0;
`endif

  assign s2_free_s = ~valid_o | ready_i;
  assign s1_adv_s  = s1_valid_r & s2_free_s;
  assign ready_o   = ~s1_valid_r | s2_free_s;
  assign accept_s  = valid_i & ready_o & ~flush_s;

  // Signed compare reuses the unsigned datapath with both MSBs flipped.
  always_comb begin
    signed_s = (br_op_i[2:1] == 2'b10);
    a_m_s    = a_i;
    b_m_s    = b_i;
    if (signed_s) begin
      a_m_s[WIDTH-1] = ~a_i[WIDTH-1];
      b_m_s[WIDTH-1] = ~b_i[WIDTH-1];
    end else begin
      a_m_s[WIDTH-1] = a_i[WIDTH-1];
      b_m_s[WIDTH-1] = b_i[WIDTH-1];
    end
  end

  // Per-chunk equal / greater-than flags evaluated in parallel.
  always_comb begin
    eq_s = '0;
    gt_s = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      eq_s[k] = (a_m_s[k*CHUNK +: CHUNK] == b_m_s[k*CHUNK +: CHUNK]);
      gt_s[k] = (a_m_s[k*CHUNK +: CHUNK] >  b_m_s[k*CHUNK +: CHUNK]);
    end
  end

  // Stage 1 register: chunk flags plus op and tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0;
      s1_eq_r    <= '0;
      s1_gt_r    <= '0;
      s1_op_r    <= 3'b000;
      s1_tag_r   <= '0;
    end else begin
      if (flush_s) begin
        s1_valid_r <= 1'b0;
      end else if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (accept_s) begin
        s1_eq_r  <= eq_s;
        s1_gt_r  <= gt_s;
        s1_op_r  <= br_op_i;
        s1_tag_r <= tag_i;
      end
    end
  end

  // Merge chunks from low to high so the highest differing chunk decides.
  always_comb begin
    equal_s   = &s1_eq_r;
    alarger_s = 1'b0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (!s1_eq_r[k]) begin
        alarger_s = s1_gt_r[k];
      end else begin
        alarger_s = alarger_s;
      end
    end
    blarger_s = ~(equal_s | alarger_s);
    illegal_s = (s1_op_r[2:1] == 2'b01);
    case (s1_op_r)
      3'b000:         taken_s = equal_s;
      3'b001:         taken_s = ~equal_s;
      3'b100, 3'b110: taken_s = blarger_s;
      3'b101, 3'b111: taken_s = ~blarger_s;
      default:        taken_s = 1'b0;
    endcase
  end

  // Stage 2 register drives the result outputs directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o   <= 1'b0;
      equal_o   <= 1'b0;
      alarger_o <= 1'b0;
      blarger_o <= 1'b0;
      taken_o   <= 1'b0;
      illegal_o <= 1'b0;
      tag_o     <= '0;
    end else begin
      if (flush_s) begin
        valid_o <= 1'b0;
      end else if (s1_adv_s) begin
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      if (s1_adv_s) begin
        equal_o   <= equal_s;
        alarger_o <= alarger_s;
        blarger_o <= blarger_s;
        taken_o   <= taken_s;
        illegal_o <= illegal_s;
        tag_o     <= s1_tag_r;
      end
    end
  end

endmodule

// File: doc/branch_compare_pipe.md
Name: branch_compare_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32-bit unsigned comparator used by the branch unit.
- Supports any operand width split into equal chunks, signed and unsigned modes, and full RV32I branch-condition resolution from funct3.
- Two register stages with valid/ready handshake on both sides. Sits between the decode/operand-read stage and the PC-select logic.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 16, chunk width compared in parallel in stage 1.
- TAG_W, 5, width of the sideband tag carried alongside each request.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  request valid
- ready_o  output  1  block can accept a request this cycle
- a_i  input  WIDTH  operand A (rs1)
- b_i  input  WIDTH  operand B (rs2)
- br_op_i  input  3  branch funct3
- tag_i  input  TAG_W  sideband tag, returned unchanged
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- equal_o  output  1  a == b
- alarger_o  output  1  a > b in the selected mode
- blarger_o  output  1  b > a in the selected mode
- taken_o  output  1  branch condition true
- illegal_o  output  1  br_op_i was 010 or 011
- tag_o  output  TAG_W  tag of the result

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_ni=0: s1_valid=0, s2_valid=0, valid_o=0, and all data outputs = 0.
  - Reset asserted mid-operation discards all in-flight requests.
- Mode decode:
  - Signed when br_op_i[2:1]=2'b10 (BLT, BGE); unsigned otherwise.
  - Signed compare = unsigned compare with the MSB of both operands inverted.
- Stage 1 (registered on transfer valid_i & ready_o):
  - For each of NCHUNK=WIDTH/CHUNK chunks, stores eq[k] = (a_k==b_k) and gt[k] = (a_k>b_k, unsigned, after MSB inversion).
  - Also stores br_op and tag.
- Stage 2 (registered on s1 advance):
  - equal = AND of all eq[k].
  - alarger = gt of the highest chunk k for which all chunks above k are equal.
  - blarger = ~(equal | alarger).
- Taken decode:
  - 000 → equal
  - 001 → ~equal
  - 100 and 110 → blarger
  - 101 and 111 → ~blarger
  - 010 and 011 → taken_o=0, illegal_o=1; the compare flags are still computed, unsigned.
- Handshake:
  - s2_free = ~s2_valid | ready_i
  - s1 advances when s1_valid & s2_free
  - ready_o = ~s1_valid | s2_free
  - ready_o is purely combinational from internal state and ready_i; it has no dependency on valid_i.
- Latency and throughput:
  - Result appears on valid_o 2 cycles after acceptance with no backpressure.
  - Throughput is 1 request per cycle.
- Stall: while valid_o=1 and ready_i=0, all outputs hold stable. The stage-1 entry holds, and ready_o=0 if s1 is occupied.
- Simultaneous events: a request is accepted in the same cycle that s1 advances. No bubble is inserted.
- When valid_o=0, data outputs are don't-care; the implementation holds the last values.
- Boundary conditions:
  - NCHUNK=1 degenerates to a single comparator.
  - WIDTH not a multiple of CHUNK is a compile-time error (elaboration assertion).

Optional Feature:
- Macro: BRANCH_COMPARE_FLUSH_EN.
- Defined:
  - Adds port flush_i (input, 1 bit).
  - flush_i=1 clears s1_valid and s2_valid at the next edge.
  - A request presented in the flush cycle is discarded even if ready_o=1.
  - valid_o=0 from the following cycle.
  - Data registers are not cleared.
- Not defined: port absent; behaviour as above.

Test Plan:
1. Reset: hold rst_ni=0 with valid_i=1 → valid_o=0 and all outputs 0. Release rst_ni and send a=5, b=5, op=000 → 2 cycles later valid_o=1, equal_o=1, taken_o=1, blarger_o=0.
2. Signed vs unsigned: a=32'hFFFF_FFFF, b=1.
   - op=100 (BLT) → alarger_o=0, blarger_o=1, taken_o=1.
   - op=110 (BLTU) → alarger_o=1, taken_o=0.
   - op=111 (BGEU) → taken_o=1.
3. Chunk boundary: a=32'h0001_0000, b=32'h0000_FFFF, op=110 → alarger_o=1, taken_o=0. Swapping operands → blarger_o=1, taken_o=1.
4. Backpressure:
   - Stream 4 back-to-back requests with tags 1..4 and hold ready_i=0 for 3 cycles → valid_o stays 1 with tag_o=1 stable, and ready_o drops after 2 accepts.
   - Release ready_i → tags 1..4 emerge in order, none lost or duplicated.
5. Illegal op: op=010, a=3, b=3 → illegal_o=1, taken_o=0, equal_o=1.
6. Flush (BRANCH_COMPARE_FLUSH_EN): 2 requests in flight, assert flush_i with a third on valid_i → valid_o=0 next cycle, and no result for any of the 3 ever appears.
